// File: rtl/charge_controller_gen2_if.sv
// Handshake and status bundle between the charger controller and its front panel / tube driver.
// The master side drives the user inputs and the second tick; the slave side is the controller.
interface charge_controller_gen2_if #(
  parameter int DIGITS = 2,
  parameter int RW     = 16
);
  logic                  tick;
  logic                  start;
  logic                  insert;
  logic [3:0]            digit;
  logic                  affirm;
  logic                  cancel;
  logic                  no_display;
  logic                  charging;
  logic                  idle_timing;
  logic [4*DIGITS-1:0]   amount;
  logic [2:0]            digit_cnt;
  logic [RW-1:0]         remaining;
  logic [2:0]            state;

  modport master (
    output tick, start, insert, digit, affirm, cancel,
    input  no_display, charging, idle_timing, amount, digit_cnt, remaining, state
  );

  modport slave (
    input  tick, start, insert, digit, affirm, cancel,
    output no_display, charging, idle_timing, amount, digit_cnt, remaining, state
  );
endinterface

// File: rtl/charge_controller_gen2.sv
// Coin-operated charger controller: BCD payment entry, idle timeout and charge countdown,
// all paced by a one-per-second tick enable. Every output is registered.
module charge_controller_gen2 #(
  parameter int DIGITS       = 2,
  parameter int IDLE_TICKS   = 10,
  parameter int SEC_PER_UNIT = 2,
  parameter int RW           = 16
) (
  input  logic                   clk,
  input  logic                   init_reset,
  charge_controller_gen2_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READY   = 3'd1,
    S_ENTRY   = 3'd2,
    S_CONFIRM = 3'd3,
    S_CHARGE  = 3'd4
  } state_e;

  localparam int            IW        = $clog2(IDLE_TICKS + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TICKS - 1);
  localparam logic [2:0]    DIGITS_L  = 3'(DIGITS);
  localparam logic [63:0]   MAX_REM   = (64'd1 << RW) - 64'd1;

  state_e                state_q, state_d;
  logic [4*DIGITS-1:0]   amount_q, amount_d, amount_shift;
  logic [2:0]            digit_cnt_q, digit_cnt_d;
  logic [RW-1:0]         remaining_q, remaining_d;
  logic [IW-1:0]         idle_cnt_q, idle_cnt_d;
  logic                  charging_q, charging_d;
  logic                  idle_timing_q, idle_timing_d;
  logic                  no_display_q, no_display_d;
  logic                  valid_insert;
  logic                  clear;

  // Charge time = decimal value of the BCD amount times SEC_PER_UNIT, clamped to the counter range.
  function automatic logic [RW-1:0] charge_secs(input logic [4*DIGITS-1:0] bcd);
    logic [63:0] acc;
    acc = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc = acc * 64'd10 + 64'(bcd[4*i +: 4]);
    end
    acc = acc * 64'(SEC_PER_UNIT);
    if (acc > MAX_REM) return '1;
    return acc[RW-1:0];
  endfunction

  assign valid_insert = bus.insert && (bus.digit <= 4'd9);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge init_reset) begin
    if (init_reset) begin
      state_q       <= S_IDLE;
      amount_q      <= '0;
      digit_cnt_q   <= '0;
      remaining_q   <= '0;
      idle_cnt_q    <= '0;
      charging_q    <= 1'b0;
      idle_timing_q <= 1'b0;
      no_display_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      amount_q      <= amount_d;
      digit_cnt_q   <= digit_cnt_d;
      remaining_q   <= remaining_d;
      idle_cnt_q    <= idle_cnt_d;
      charging_q    <= charging_d;
      idle_timing_q <= idle_timing_d;
      no_display_q  <= no_display_d;
    end
  end

  // Event priority inside each state: cancel > affirm > insert > tick.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d      = state_q;
    amount_d     = amount_q;
    digit_cnt_d  = digit_cnt_q;
    remaining_d  = remaining_q;
    idle_cnt_d   = idle_cnt_q;
    clear        = 1'b0;
    amount_shift = amount_q << 4;
    amount_shift[3:0] = bus.digit;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_READY;
          clear   = 1'b1;
        end
      end
      S_READY, S_ENTRY, S_CONFIRM: begin
        if (bus.cancel) begin
          state_d = S_READY;
          clear   = 1'b1;
        end else if (bus.affirm && state_q != S_READY && amount_q != '0) begin
          state_d     = S_CHARGE;
          remaining_d = charge_secs(amount_q);
          idle_cnt_d  = '0;
        end else if (bus.affirm && state_q == S_CONFIRM) begin
          state_d = S_READY;
          clear   = 1'b1;
        end else if (valid_insert && state_q != S_CONFIRM) begin
          amount_d    = amount_shift;
          digit_cnt_d = digit_cnt_q + 3'd1;
          idle_cnt_d  = '0;
          state_d     = (digit_cnt_q + 3'd1 == DIGITS_L) ? S_CONFIRM : S_ENTRY;
        end else if (bus.tick) begin
          if (idle_cnt_q == IDLE_LAST) begin
            state_d = S_IDLE;
            clear   = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      S_CHARGE: begin
        if (bus.cancel) begin
          state_d = S_READY;
          clear   = 1'b1;
        end else if (bus.tick) begin
          if (remaining_q <= RW'(1)) begin
            state_d = S_READY;
            clear   = 1'b1;
          end else begin
            remaining_d = remaining_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        clear   = 1'b1;
      end
    endcase

    if (clear) begin
      amount_d    = '0;
      digit_cnt_d = '0;
      remaining_d = '0;
      idle_cnt_d  = '0;
    end
  end

  // Status flags are decoded from the next state so they land on the same edge as the transition.
  always_comb begin
    charging_d    = (state_d == S_CHARGE);
    idle_timing_d = (state_d == S_READY) || (state_d == S_ENTRY) || (state_d == S_CONFIRM);
    no_display_d  = (state_d == S_IDLE);
  end

  assign bus.state       = state_q;
  assign bus.amount      = amount_q;
  assign bus.digit_cnt   = digit_cnt_q;
  assign bus.remaining   = remaining_q;
  assign bus.charging    = charging_q;
  assign bus.idle_timing = idle_timing_q;
  assign bus.no_display  = no_display_q;

endmodule

// File: tb/tb_charge_controller_gen2.sv
// Directed bench for charge_controller_gen2: a default instance plus an RW=6 instance sharing
// the same stimulus, the second one exposing remaining-time saturation.
module tb_charge_controller_gen2;

  logic       clk = 1'b0;
  logic       init_reset;
  logic       tick, start, insert, affirm, cancel;
  logic [3:0] digit;
  int         n_tests = 0;
  int         n_fail  = 0;

  charge_controller_gen2_if #(.DIGITS(2), .RW(16)) bus_a ();
  charge_controller_gen2_if #(.DIGITS(2), .RW(6))  bus_b ();

  assign bus_a.tick = tick;   assign bus_b.tick = tick;
  assign bus_a.start = start; assign bus_b.start = start;
  assign bus_a.insert = insert; assign bus_b.insert = insert;
  assign bus_a.digit = digit; assign bus_b.digit = digit;
  assign bus_a.affirm = affirm; assign bus_b.affirm = affirm;
  assign bus_a.cancel = cancel; assign bus_b.cancel = cancel;

  charge_controller_gen2 #(.DIGITS(2), .IDLE_TICKS(10), .SEC_PER_UNIT(2), .RW(16)) dut_a (
    .clk(clk), .init_reset(init_reset), .bus(bus_a)
  );
  charge_controller_gen2 #(.DIGITS(2), .IDLE_TICKS(10), .SEC_PER_UNIT(2), .RW(6)) dut_b (
    .clk(clk), .init_reset(init_reset), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Full observable state of the default instance; flags follow from the expected state.
  task automatic check_a(input string tag, input int st, input int amt, input int cnt,
                         input int rem);
    check({tag, ".state"},      32'(bus_a.state),       32'(st));
    check({tag, ".amount"},     32'(bus_a.amount),      32'(amt));
    check({tag, ".digit_cnt"},  32'(bus_a.digit_cnt),   32'(cnt));
    check({tag, ".remaining"},  32'(bus_a.remaining),   32'(rem));
    check({tag, ".charging"},   32'(bus_a.charging),    32'(st == 4));
    check({tag, ".idle_tmg"},   32'(bus_a.idle_timing), 32'(st >= 1 && st <= 3));
    check({tag, ".no_disp"},    32'(bus_a.no_display),  32'(st == 0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_insert(input logic [3:0] d);
    insert = 1'b1; digit = d; step(); insert = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
    end
  endtask

  initial begin
    init_reset = 1'b1;
    tick = 1'b0; start = 1'b0; insert = 1'b0; affirm = 1'b0; cancel = 1'b0; digit = 4'd0;
    step(); step();
    check_a("reset", 0, 0, 0, 0);
    check("reset.b_rem", 32'(bus_b.remaining), 32'd0);
    init_reset = 1'b0;
    step();

    // Cancel while idle does nothing.
    cancel = 1'b1; step(); cancel = 1'b0;
    check_a("idle_cancel", 0, 0, 0, 0);

    // Full payment: 35 units -> 70 s (RW=6 instance saturates at 63).
    start = 1'b1; step(); start = 1'b0;
    check_a("start", 1, 0, 0, 0);
    do_insert(4'd3);
    check_a("ins3", 2, 8'h03, 1, 0);
    do_insert(4'd5);
    check_a("ins5", 3, 8'h35, 2, 0);
    affirm = 1'b1; step(); affirm = 1'b0;
    check_a("affirm35", 4, 8'h35, 2, 70);
    check("affirm35.b_rem", 32'(bus_b.remaining), 32'd63);
    do_ticks(69);
    check_a("tick69", 4, 8'h35, 2, 1);
    do_ticks(1);
    check_a("charge_done", 1, 0, 0, 0);

    // Early affirm with one digit, then an insert that must be ignored, then cancel.
    do_insert(4'd4);
    check_a("early_ins4", 2, 8'h04, 1, 0);
    affirm = 1'b1; step(); affirm = 1'b0;
    check_a("early_affirm", 4, 8'h04, 1, 8);
    do_insert(4'd7);
    check_a("charge_ins_ign", 4, 8'h04, 1, 8);
    cancel = 1'b1; step(); cancel = 1'b0;
    check_a("cancel_early", 1, 0, 0, 0);

    // Mid-charge cancel at remaining = 40.
    do_insert(4'd2);
    do_insert(4'd5);
    affirm = 1'b1; step(); affirm = 1'b0;
    check_a("affirm25", 4, 8'h25, 2, 50);
    check("affirm25.b_rem", 32'(bus_b.remaining), 32'd50);
    do_ticks(10);
    check_a("rem40", 4, 8'h25, 2, 40);
    cancel = 1'b1; step(); cancel = 1'b0;
    check_a("cancel40", 1, 0, 0, 0);

    // Invalid digit, zero amount, insert ignored in CONFIRM, zero affirm returns to READY.
    do_insert(4'd12);
    check_a("ins12", 1, 0, 0, 0);
    do_insert(4'd0);
    check_a("ins0a", 2, 0, 1, 0);
    do_insert(4'd0);
    check_a("ins0b", 3, 0, 2, 0);
    do_insert(4'd9);
    check_a("confirm_ins_ign", 3, 0, 2, 0);
    affirm = 1'b1; step(); affirm = 1'b0;
    check_a("affirm_zero", 1, 0, 0, 0);

    // Idle timeout after 10 ticks in READY.
    do_ticks(9);
    check_a("idle9", 1, 0, 0, 0);
    do_ticks(1);
    check_a("idle_timeout", 0, 0, 0, 0);

    // Insert on the 10th tick wins and restarts the idle count.
    start = 1'b1; step(); start = 1'b0;
    do_ticks(9);
    tick = 1'b1; insert = 1'b1; digit = 4'd6; step();
    tick = 1'b0; insert = 1'b0;
    check_a("tick_ins_race", 2, 8'h06, 1, 0);
    do_ticks(9);
    check_a("entry_idle9", 2, 8'h06, 1, 0);
    do_ticks(1);
    check_a("entry_timeout", 0, 0, 0, 0);

    // Saturation: 99 units -> 198 s, RW=6 instance clamps to 63.
    start = 1'b1; step(); start = 1'b0;
    do_insert(4'd9);
    do_insert(4'd9);
    affirm = 1'b1; step(); affirm = 1'b0;
    check_a("affirm99", 4, 8'h99, 2, 198);
    check("affirm99.b_rem", 32'(bus_b.remaining), 32'd63);
    do_ticks(5);
    check("tick5.a_rem", 32'(bus_a.remaining), 32'd193);
    check("tick5.b_rem", 32'(bus_b.remaining), 32'd58);

    // Asynchronous reset mid-charge takes effect without a clock edge.
    init_reset = 1'b1;
    #1;
    check_a("async_rst", 0, 0, 0, 0);
    check("async_rst.b_rem", 32'(bus_b.remaining), 32'd0);
    check("async_rst.b_chg", 32'(bus_b.charging), 32'd0);
    step();
    init_reset = 1'b0;
    step();
    check_a("post_rst", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
